// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Groups the two requester ports (A = CPU, B = DMA), the shared bus command and
// response, and the sticky timeout flag of bus_arbiter.
//   slave  : arbiter view (requester commands and bus response in; requester
//            responses, bus command and timeout flag out)
//   master : environment view (requesters plus the bus target), mirror of slave
// Signal names keep their i_/o_ prefixes as seen from the arbiter.
// -----------------------------------------------------------------------------
interface bus_arbiter_if;
  // requester A
  logic        i_pa_request;
  logic        i_pa_rw;
  logic [31:0] i_pa_address;
  logic [31:0] i_pa_wdata;
  logic [31:0] o_pa_rdata;
  logic        o_pa_ready;
  // requester B
  logic        i_pb_request;
  logic        i_pb_rw;
  logic [31:0] i_pb_address;
  logic [31:0] i_pb_wdata;
  logic [31:0] o_pb_rdata;
  logic        o_pb_ready;
  // shared bus
  logic        o_bus_request;
  logic        o_bus_rw;
  logic [31:0] o_bus_address;
  logic [31:0] o_bus_wdata;
  logic [31:0] i_bus_rdata;
  logic        i_bus_ready;
  // status
  logic        o_timeout;

  modport slave (
    input  i_pa_request, i_pa_rw, i_pa_address, i_pa_wdata,
    output o_pa_rdata, o_pa_ready,
    input  i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata,
    output o_pb_rdata, o_pb_ready,
    output o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    input  i_bus_rdata, i_bus_ready,
    output o_timeout
  );

  modport master (
    output i_pa_request, i_pa_rw, i_pa_address, i_pa_wdata,
    input  o_pa_rdata, o_pa_ready,
    output i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata,
    input  o_pb_rdata, o_pb_ready,
    input  o_bus_request, o_bus_rw, o_bus_address, o_bus_wdata,
    output i_bus_rdata, i_bus_ready,
    input  o_timeout
  );
endinterface

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Two-requester round-robin arbiter in front of a single shared bus.
// IDLE picks a requester (round-robin when both ask), BUSY forwards the granted
// requester's command combinationally and routes the bus response back to it.
// A transaction ends on i_bus_ready, or is aborted when the granted request drops.
//
// Ports:
//   i_clock    : system clock, rising edge
//   i_reset_n  : asynchronous active-low reset
//   arb        : bus_arbiter_if.slave (requesters A/B, shared bus, o_timeout)
// Parameter:
//   TIMEOUT    : bus cycles before a stalled transaction is force-completed
//                (2..65535); only meaningful with the watchdog enabled
// Configuration:
//   BUS_ARBITER_TIMEOUT_EN : when defined, adds the stall watchdog and drives
//                            the sticky o_timeout flag; otherwise o_timeout=0
// -----------------------------------------------------------------------------
module bus_arbiter #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         i_clock,
  input  logic         i_reset_n,
  bus_arbiter_if.slave arb
);

  if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
    $error("bus_arbiter: TIMEOUT must be within 2..65535");
  end

  typedef enum logic {IDLE, BUSY} state_t;

  state_t state;
  logic   grant;        // 0 = A, 1 = B
  logic   last_grant;   // requester that completed most recently
  logic   granted_request;
  logic   force_done;   // watchdog completion this cycle

  assign granted_request = grant ? arb.i_pb_request : arb.i_pa_request;

`ifdef BUS_ARBITER_TIMEOUT_EN
  logic [15:0] count;
  logic        timeout_flag;

  // Bus ready wins over the watchdog, and a dropped request is an abort, so
  // the forced completion only fires on a genuinely stalled, live transaction.
  assign force_done = (state == BUSY) && granted_request && !arb.i_bus_ready
                      && (count == 16'(TIMEOUT - 1));
  assign arb.o_timeout = timeout_flag;
`else
  assign force_done    = 1'b0;
  assign arb.o_timeout = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;   // A wins the first contested arbitration
`ifdef BUS_ARBITER_TIMEOUT_EN
      count        <= '0;
      timeout_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (arb.i_pa_request || arb.i_pb_request) begin
            state <= BUSY;
            grant <= (arb.i_pa_request && arb.i_pb_request) ? ~last_grant
                                                            : arb.i_pb_request;
`ifdef BUS_ARBITER_TIMEOUT_EN
            count <= '0;
`endif
          end
        end
        BUSY: begin
          if (!granted_request) begin
            // abort: the transaction never completed, fairness is unchanged
            state <= IDLE;
          end else if (arb.i_bus_ready || force_done) begin
            state      <= IDLE;
            last_grant <= grant;
`ifdef BUS_ARBITER_TIMEOUT_EN
            if (force_done) timeout_flag <= 1'b1;
`endif
          end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
            count <= count + 16'd1;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register, so an asynchronous reset
  // drops the bus request and both readies without waiting for an edge.
  // NOTE: every output gets a default before the case logic; a path that
  // leaves one unassigned would infer a latch.
  always_comb begin
    arb.o_bus_request = 1'b0;
    arb.o_bus_rw      = 1'b0;
    arb.o_bus_address = '0;
    arb.o_bus_wdata   = '0;
    arb.o_pa_ready    = 1'b0;
    arb.o_pa_rdata    = '0;
    arb.o_pb_ready    = 1'b0;
    arb.o_pb_rdata    = '0;
    if (state == BUSY) begin
      arb.o_bus_request = granted_request && !force_done;
      if (grant) begin
        arb.o_bus_rw      = arb.i_pb_rw;
        arb.o_bus_address = arb.i_pb_address;
        arb.o_bus_wdata   = arb.i_pb_wdata;
        arb.o_pb_ready    = force_done | arb.i_bus_ready;
        arb.o_pb_rdata    = force_done ? '0 : arb.i_bus_rdata;
      end else begin
        arb.o_bus_rw      = arb.i_pa_rw;
        arb.o_bus_address = arb.i_pa_address;
        arb.o_bus_wdata   = arb.i_pa_wdata;
        arb.o_pa_ready    = force_done | arb.i_bus_ready;
        arb.o_pa_rdata    = force_done ? '0 : arb.i_bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter (TIMEOUT=8). Inputs change at the falling
// edge, outputs are compared 1 ns later, well away from the rising edge.
// Expectations follow the BUS_ARBITER_TIMEOUT_EN setting of the build.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  bus_arbiter_if bif ();

  bus_arbiter #(.TIMEOUT(8)) dut (
    .i_clock   (clk),
    .i_reset_n (rst_n),
    .arb       (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    bif.i_pa_request = 1'b0; bif.i_pa_rw = 1'b0;
    bif.i_pa_address = '0;   bif.i_pa_wdata = '0;
    bif.i_pb_request = 1'b0; bif.i_pb_rw = 1'b0;
    bif.i_pb_address = '0;   bif.i_pb_wdata = '0;
    bif.i_bus_ready  = 1'b0; bif.i_bus_rdata = '0;

    // ---- reset state
    repeat (2) cyc();
    #1;
    check("rst_bus_req",  32'(bif.o_bus_request), 32'd0);
    check("rst_bus_addr", bif.o_bus_address,      32'd0);
    check("rst_pa_ready", 32'(bif.o_pa_ready),    32'd0);
    check("rst_timeout",  32'(bif.o_timeout),     32'd0);
    cyc(); rst_n = 1'b1;

    // ---- A alone reads 0x00010004, bus ready in the third BUSY cycle
    bif.i_pa_request = 1'b1; bif.i_pa_rw = 1'b0; bif.i_pa_address = 32'h0001_0004;
    #1 check("a_idle_req", 32'(bif.o_bus_request), 32'd0);
    cyc(); #1;
    check("a_busy_req",  32'(bif.o_bus_request), 32'd1);
    check("a_busy_addr", bif.o_bus_address,      32'h0001_0004);
    check("a_busy_rw",   32'(bif.o_bus_rw),      32'd0);
    check("a_busy_rdy",  32'(bif.o_pa_ready),    32'd0);
    check("a_busy_brdy", 32'(bif.o_pb_ready),    32'd0);
    cyc(); #1;
    check("a_wait_rdy",  32'(bif.o_pa_ready),    32'd0);
    cyc(); bif.i_bus_ready = 1'b1; bif.i_bus_rdata = 32'h1234_5678;
    #1;
    check("a_done_rdy",   32'(bif.o_pa_ready), 32'd1);
    check("a_done_rdata", bif.o_pa_rdata,      32'h1234_5678);
    check("a_done_brdy",  32'(bif.o_pb_ready), 32'd0);
    check("a_done_bdata", bif.o_pb_rdata,      32'd0);
    cyc(); bif.i_bus_ready = 1'b0; bif.i_bus_rdata = '0; bif.i_pa_request = 1'b0;
    #1;
    check("a_after_req", 32'(bif.o_bus_request), 32'd0);
    check("a_after_rdy", 32'(bif.o_pa_ready),    32'd0);

    // ---- both requesting from reset: A,B,A,B with one IDLE cycle between
    cyc(); rst_n = 1'b0;
    bif.i_pa_request = 1'b1; bif.i_pa_address = 32'hA000_0000;
    bif.i_pb_request = 1'b1; bif.i_pb_address = 32'hB000_0000;
    bif.i_bus_ready  = 1'b1; bif.i_bus_rdata  = 32'h5555_AAAA;
    cyc(); rst_n = 1'b1;
    #1;
    check("rr_idle_req", 32'(bif.o_bus_request), 32'd0);
    check("rr_idle_rdy", 32'(bif.o_pa_ready),    32'd0);
    for (int i = 0; i < 4; i++) begin
      logic exp_b;
      exp_b = 1'(i & 1);
      cyc(); #1;
      check($sformatf("rr%0d_req", i),  32'(bif.o_bus_request), 32'd1);
      check($sformatf("rr%0d_addr", i), bif.o_bus_address,
            exp_b ? 32'hB000_0000 : 32'hA000_0000);
      check($sformatf("rr%0d_pa", i),   32'(bif.o_pa_ready), 32'(!exp_b));
      check($sformatf("rr%0d_pb", i),   32'(bif.o_pb_ready), 32'(exp_b));
      cyc(); #1;
      check($sformatf("rr%0d_gap", i),  32'(bif.o_bus_request), 32'd0);
    end
    bif.i_pa_request = 1'b0; bif.i_pb_request = 1'b0; bif.i_bus_ready = 1'b0;

    // ---- B writes, A asks mid-transaction, A served next
    bif.i_pb_request = 1'b1; bif.i_pb_rw = 1'b1;
    bif.i_pb_address = 32'h5000_0000; bif.i_pb_wdata = 32'h0000_03FF;
    cyc(); #1;
    check("b_wr_req",   32'(bif.o_bus_request), 32'd1);
    check("b_wr_addr",  bif.o_bus_address,      32'h5000_0000);
    check("b_wr_wdata", bif.o_bus_wdata,        32'h0000_03FF);
    check("b_wr_rw",    32'(bif.o_bus_rw),      32'd1);
    bif.i_pa_request = 1'b1; bif.i_pa_rw = 1'b0;
    bif.i_pa_address = 32'h0000_1111; bif.i_pa_wdata = 32'h0000_AAAA;
    #1;
    check("b_mid_addr",  bif.o_bus_address,   32'h5000_0000);
    check("b_mid_wdata", bif.o_bus_wdata,     32'h0000_03FF);
    check("b_mid_pardy", 32'(bif.o_pa_ready), 32'd0);
    cyc(); #1;
    check("b_hold_addr", bif.o_bus_address, 32'h5000_0000);
    bif.i_bus_ready = 1'b1;
    #1;
    check("b_done_pb", 32'(bif.o_pb_ready), 32'd1);
    check("b_done_pa", 32'(bif.o_pa_ready), 32'd0);
    cyc(); bif.i_bus_ready = 1'b0; bif.i_pb_request = 1'b0;
    #1 check("b_gap_req", 32'(bif.o_bus_request), 32'd0);
    cyc(); #1;
    check("a_next_addr", bif.o_bus_address,   32'h0000_1111);
    check("a_next_rw",   32'(bif.o_bus_rw),   32'd0);
    bif.i_bus_ready = 1'b1;
    #1 check("a_next_rdy", 32'(bif.o_pa_ready), 32'd1);
    cyc(); bif.i_bus_ready = 1'b0; bif.i_pa_request = 1'b0;

    // ---- reset pulsed while A is granted
    bif.i_pa_request = 1'b1; bif.i_pa_address = 32'h2222_0000;
    cyc(); #1;
    check("r_busy_req", 32'(bif.o_bus_request), 32'd1);
    #1 rst_n = 1'b0; bif.i_bus_ready = 1'b1;
    #1;
    check("r_async_req", 32'(bif.o_bus_request), 32'd0);
    check("r_async_pa",  32'(bif.o_pa_ready),    32'd0);
    check("r_async_pb",  32'(bif.o_pb_ready),    32'd0);
    cyc(); bif.i_bus_ready = 1'b0;
    bif.i_pb_request = 1'b1; bif.i_pb_address = 32'h3333_0000;
    rst_n = 1'b1;
    cyc(); #1;
    check("r_first_addr", bif.o_bus_address, 32'h2222_0000);
    bif.i_bus_ready = 1'b1;
    cyc(); bif.i_bus_ready = 1'b0;
    cyc(); #1;
    check("r_second_addr", bif.o_bus_address, 32'h3333_0000);
    bif.i_bus_ready = 1'b1;
    #1 check("r_second_pb", 32'(bif.o_pb_ready), 32'd1);
    cyc(); bif.i_bus_ready = 1'b0; bif.i_pa_request = 1'b0; bif.i_pb_request = 1'b0;

    // ---- A aborts; last-granted stays B so A wins the next contest
    bif.i_pa_request = 1'b1; bif.i_pa_address = 32'h4444_0000;
    cyc(); #1;
    check("ab_busy_addr", bif.o_bus_address, 32'h4444_0000);
    bif.i_pa_request = 1'b0;
    #1 check("ab_drop_req", 32'(bif.o_bus_request), 32'd0);
    cyc(); #1;
    check("ab_idle_addr", bif.o_bus_address, 32'd0);
    bif.i_pa_request = 1'b1;
    bif.i_pb_request = 1'b1; bif.i_pb_address = 32'h5555_0000;
    cyc(); #1;
    check("ab_regrant", bif.o_bus_address, 32'h4444_0000);
    bif.i_bus_ready = 1'b1;
    cyc(); bif.i_bus_ready = 1'b0; bif.i_pa_request = 1'b0; bif.i_pb_request = 1'b0;

    // ---- stalled bus
    bif.i_pa_request = 1'b1; bif.i_pa_address = 32'h6666_0000; bif.i_pa_rw = 1'b0;
    bif.i_bus_rdata  = 32'hDEAD_BEEF;
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int c = 1; c <= 8; c++) begin
      cyc(); #1;
      if (c < 8) begin
        check($sformatf("to_c%0d_req", c), 32'(bif.o_bus_request), 32'd1);
        check($sformatf("to_c%0d_rdy", c), 32'(bif.o_pa_ready),    32'd0);
      end else begin
        check("to_fire_req",   32'(bif.o_bus_request), 32'd0);
        check("to_fire_rdy",   32'(bif.o_pa_ready),    32'd1);
        check("to_fire_rdata", bif.o_pa_rdata,         32'd0);
        check("to_fire_flag",  32'(bif.o_timeout),     32'd0);
      end
    end
    cyc(); bif.i_pa_request = 1'b0;
    #1;
    check("to_flag_set", 32'(bif.o_timeout),     32'd1);
    check("to_idle_req", 32'(bif.o_bus_request), 32'd0);
    repeat (3) cyc();
    #1 check("to_flag_sticky", 32'(bif.o_timeout), 32'd1);
`else
    for (int c = 1; c <= 20; c++) begin
      cyc(); #1;
      check($sformatf("stall_c%0d_req", c), 32'(bif.o_bus_request), 32'd1);
      check($sformatf("stall_c%0d_rdy", c), 32'(bif.o_pa_ready),    32'd0);
    end
    check("stall_flag", 32'(bif.o_timeout), 32'd0);
    bif.i_pa_request = 1'b0;
    cyc(); #1;
    check("stall_end_req", 32'(bif.o_bus_request), 32'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024, meaning bus cycles before a stalled transaction is force-completed (range 2..65535).
REQ-002 SHALL have port i_clock  input  1  system clock, all state on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have ports i_pa_request  input  1 / i_pa_rw  input  1 / i_pa_address  input  32 / i_pa_wdata  input  32: requester A (CPU) command; rw=1 write.
REQ-005 SHALL have ports o_pa_rdata  output  32 / o_pa_ready  output  1: requester A response.
REQ-006 SHALL have ports i_pb_request, i_pb_rw, i_pb_address, i_pb_wdata, o_pb_rdata, o_pb_ready: requester B (DMA), same widths and meaning as A.
REQ-007 SHALL have ports o_bus_request  output  1 / o_bus_rw  output  1 / o_bus_address  output  32 / o_bus_wdata  output  32: shared bus command to address decoder.
REQ-008 SHALL have ports i_bus_rdata  input  32 / i_bus_ready  input  1: shared bus response.
REQ-009 SHALL have port o_timeout  output  1  sticky flag, a transaction was force-completed.

Function
REQ-010 SHALL implement states IDLE and BUSY plus a 1-bit grant register (0=A, 1=B) and a 1-bit last-granted register.
REQ-011 IDLE: o_bus_request=0; o_bus_rw/address/wdata=0; both o_pX_ready=0; o_pX_rdata=0.
REQ-012 IDLE with exactly one request high: next cycle BUSY, grant=that requester.
REQ-013 IDLE with both requests high: grant the requester not equal to last-granted (round-robin).
REQ-014 BUSY: o_bus_request=granted request; o_bus_rw/address/wdata combinationally muxed from granted port.
REQ-015 BUSY: granted o_pX_ready=i_bus_ready, granted o_pX_rdata=i_bus_rdata; non-granted port ready=0, rdata=0.
REQ-016 BUSY and i_bus_ready=1 sampled: transaction completes; next cycle IDLE; last-granted<=grant.
REQ-017 Arbitration latency: request seen in IDLE at edge N reaches o_bus_request after edge N; minimum 2 cycles between back-to-back grants (one IDLE cycle).
REQ-018 BUSY and granted request drops before ready: abort, next cycle IDLE, last-granted unchanged.
REQ-019 Non-granted request arriving or held during BUSY: ignored, no effect on current transaction; serviced at next IDLE.
REQ-020 i_bus_ready in IDLE: ignored.
REQ-021 Requester SHALL hold command stable while request high; arbiter does not register command fields.

Reset
REQ-022 i_reset_n low: asynchronously force IDLE, grant=0, last-granted=1 (A favoured first), timeout counter=0, o_timeout=0.
REQ-023 Reset asserted mid-transaction: o_bus_request and both o_pX_ready low without waiting for a clock edge; no completion reported.
REQ-024 Reset deassertion: first arbitration on the first rising edge with i_reset_n high.

Configuration
REQ-025 Macro BUS_ARBITER_TIMEOUT_EN SHALL enable the stall watchdog.
REQ-026 Enabled: 16-bit counter cleared on IDLE->BUSY, increments each BUSY cycle with i_bus_ready=0; count reaching TIMEOUT-1 forces granted o_pX_ready=1 and o_pX_rdata=0 that cycle, o_bus_request=0, next state IDLE, o_timeout<=1 (sticky until reset).
REQ-027 Disabled: no counter logic, BUSY waits indefinitely for i_bus_ready or request drop, o_timeout tied 0; port list unchanged.

Verification
REQ-028 A only: A reads 0x00010004, bus ready after 3 BUSY cycles with rdata 0x12345678 -> o_pa_ready one cycle, o_pa_rdata=0x12345678, o_pb_ready never high.
REQ-029 Both request continuously from reset -> grants A,B,A,B, each separated by one IDLE cycle.
REQ-030 B granted writing 0x50000000 data 0x3FF, A raises request mid-transaction -> bus fields stay B's until ready; A granted next.
REQ-031 A granted, reset pulsed low mid-transaction -> o_bus_request=0 immediately, after release A then B requesting gets A first.
REQ-032 With BUS_ARBITER_TIMEOUT_EN, TIMEOUT=8, bus ready never asserted -> o_pa_ready high in BUSY cycle 8 with rdata 0, o_timeout=1 and stays 1; without macro, bus stays requested indefinitely.
REQ-033 A granted drops request before ready -> IDLE next cycle; A re-requesting alongside B is granted first (last-granted unchanged).
